// File: rtl/cluster_chunk_sched.sv
// Chunk scheduler for the compute cluster in channel-padding mode.
// Meters upstream beats into double-buffered IFM/filter chunk stores, launches
// chunk computes as banks fill, and sweeps the CU output buffers out at job end.
module cluster_chunk_sched #(
   parameter int unsigned CU_NUM = 8,
   parameter int unsigned WR_CYC = 4,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      start_i,
   input  logic [CNT_W-1:0]          chunk_num_i,
   output logic                      busy_o,
   output logic                      done_o,
   input  logic                      src_valid_i,
   output logic                      src_ready_o,
   output logic                      ifm_chunk_wr_valid_o,
   output logic [$clog2(WR_CYC)-1:0] ifm_chunk_wr_count_o,
   output logic                      ifm_chunk_wr_sel_o,
   output logic                      fil_chunk_wr_valid_o,
   output logic [$clog2(WR_CYC)-1:0] fil_chunk_wr_count_o,
   output logic                      fil_chunk_wr_sel_o,
   output logic [CU_NUM-1:0]         fil_chunk_cu_wr_sel_o,
   output logic                      ifm_chunk_rd_sel_o,
   output logic                      fil_chunk_rd_sel_o,
   output logic                      total_chunk_start_o,
   output logic                      run_valid_o,
   input  logic                      total_chunk_end_i,
   output logic [$clog2(CU_NUM)-1:0] com_unit_out_buf_sel_o,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic                      out_last_o
);

   localparam int unsigned BeatW = $clog2(WR_CYC);
   localparam int unsigned SelW  = $clog2(CU_NUM);

   typedef enum logic [1:0] {StIdle, StActive, StDrain} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  chunk_num_q, chunk_num_d;
   logic [CNT_W-1:0]  load_cnt_q, load_cnt_d;
   logic [CNT_W-1:0]  comp_cnt_q, comp_cnt_d;
   logic              wr_bank_q, wr_bank_d;
   logic              rd_bank_q, rd_bank_d;
   logic [1:0]        full_q, full_d;
   logic              ifm_phase_q, ifm_phase_d;
   logic [SelW-1:0]   cu_idx_q, cu_idx_d;
   logic [BeatW-1:0]  beat_cnt_q, beat_cnt_d;
   logic              run_q, run_d;
   logic              start_q, start_d;
   logic [SelW-1:0]   out_sel_q, out_sel_d;
   logic              done_q, done_d;

   logic              beat_acc;
   logic              beat_wrap;
   logic              last_beat;
   logic              comp_end;

   assign src_ready_o = (state_q == StActive) && (load_cnt_q < chunk_num_q) && !full_q[wr_bank_q];
   assign beat_acc    = src_valid_i && src_ready_o;
   assign beat_wrap   = beat_cnt_q == BeatW'(WR_CYC - 1);
   assign last_beat   = beat_acc && beat_wrap && !ifm_phase_q && (cu_idx_q == SelW'(CU_NUM - 1));
   // End is only meaningful while a chunk compute is running.
   assign comp_end    = run_q && total_chunk_end_i;

   // Write strobes follow the accepted beat with no register stage.
   assign ifm_chunk_wr_valid_o  = beat_acc && ifm_phase_q;
   assign fil_chunk_wr_valid_o  = beat_acc && !ifm_phase_q;
   assign ifm_chunk_wr_count_o  = beat_cnt_q;
   assign fil_chunk_wr_count_o  = beat_cnt_q;
   assign ifm_chunk_wr_sel_o    = wr_bank_q;
   assign fil_chunk_wr_sel_o    = wr_bank_q;
   assign fil_chunk_cu_wr_sel_o = ifm_phase_q ? '0 : (CU_NUM'(1) << cu_idx_q);

   assign ifm_chunk_rd_sel_o     = rd_bank_q;
   assign fil_chunk_rd_sel_o     = rd_bank_q;
   assign total_chunk_start_o    = start_q;
   assign run_valid_o            = run_q;
   assign busy_o                 = state_q != StIdle;
   assign done_o                 = done_q;
   assign out_valid_o            = state_q == StDrain;
   assign com_unit_out_buf_sel_o = out_sel_q;
   assign out_last_o             = (state_q == StDrain) && (out_sel_q == SelW'(CU_NUM - 1));

   // State register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         chunk_num_q <= '0;
         load_cnt_q  <= '0;
         comp_cnt_q  <= '0;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         full_q      <= 2'b00;
         ifm_phase_q <= 1'b1;
         cu_idx_q    <= '0;
         beat_cnt_q  <= '0;
         run_q       <= 1'b0;
         start_q     <= 1'b0;
         out_sel_q   <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         chunk_num_q <= chunk_num_d;
         load_cnt_q  <= load_cnt_d;
         comp_cnt_q  <= comp_cnt_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         full_q      <= full_d;
         ifm_phase_q <= ifm_phase_d;
         cu_idx_q    <= cu_idx_d;
         beat_cnt_q  <= beat_cnt_d;
         run_q       <= run_d;
         start_q     <= start_d;
         out_sel_q   <= out_sel_d;
         done_q      <= done_d;
      end
   end

   // Next-state: job control, loader beat index, bank bookkeeping, compute launch, drain.
   always_comb begin
      state_d     = state_q;
      chunk_num_d = chunk_num_q;
      load_cnt_d  = load_cnt_q;
      comp_cnt_d  = comp_cnt_q;
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      full_d      = full_q;
      ifm_phase_d = ifm_phase_q;
      cu_idx_d    = cu_idx_q;
      beat_cnt_d  = beat_cnt_q;
      run_d       = run_q;
      start_d     = 1'b0;
      out_sel_d   = out_sel_q;
      done_d      = 1'b0;

      case (state_q)
         StIdle: begin
            if (start_i) begin
               chunk_num_d = chunk_num_i;
               load_cnt_d  = '0;
               comp_cnt_d  = '0;
               wr_bank_d   = 1'b0;
               rd_bank_d   = 1'b0;
               full_d      = 2'b00;
               ifm_phase_d = 1'b1;
               cu_idx_d    = '0;
               beat_cnt_d  = '0;
               out_sel_d   = '0;
               if (chunk_num_i == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = StActive;
               end
            end
         end

         StActive: begin
            // Beat order: IFM beats, then one beat group per CU.
            if (beat_acc) begin
               if (beat_wrap) begin
                  beat_cnt_d = '0;
                  if (ifm_phase_q) begin
                     ifm_phase_d = 1'b0;
                     cu_idx_d    = '0;
                  end else if (cu_idx_q == SelW'(CU_NUM - 1)) begin
                     ifm_phase_d = 1'b1;
                     cu_idx_d    = '0;
                  end else begin
                     cu_idx_d = cu_idx_q + 1'b1;
                  end
               end else begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end

            if (last_beat) begin
               full_d[wr_bank_q] = 1'b1;
               wr_bank_d         = ~wr_bank_q;
               load_cnt_d        = load_cnt_q + 1'b1;
            end

            // The running bank is still full, so set and clear never hit the same bank.
            if (comp_end) begin
               full_d[rd_bank_q] = 1'b0;
               rd_bank_d         = ~rd_bank_q;
               comp_cnt_d        = comp_cnt_q + 1'b1;
               run_d             = 1'b0;
            end

            // Launch looks at next-state bank flags so a just-filled bank starts next cycle.
            if ((!run_q || comp_end) && full_d[rd_bank_d] && (comp_cnt_d < chunk_num_q)) begin
               start_d = 1'b1;
               run_d   = 1'b1;
            end

            if (comp_end && (comp_cnt_d == chunk_num_q)) begin
               state_d   = StDrain;
               out_sel_d = '0;
            end
         end

         StDrain: begin
            if (out_ready_i) begin
               if (out_sel_q == SelW'(CU_NUM - 1)) begin
                  state_d   = StIdle;
                  out_sel_d = '0;
                  done_d    = 1'b1;
               end else begin
                  out_sel_d = out_sel_q + 1'b1;
               end
            end
         end

         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_cluster_chunk_sched.sv
// Self-checking bench for cluster_chunk_sched: random stimulus compared each
// cycle against a chunk/beat counting model of the scheduler.
module tb_cluster_chunk_sched;

   localparam int unsigned CU_NUM = 8;
   localparam int unsigned WR_CYC = 4;
   localparam int unsigned CNT_W  = 16;
   localparam int          BEATS  = WR_CYC * (1 + CU_NUM);

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b1;
   logic              start_i = 1'b0;
   logic [CNT_W-1:0]  chunk_num_i = '0;
   logic              busy_o, done_o;
   logic              src_valid_i = 1'b0;
   logic              src_ready_o;
   logic              ifm_chunk_wr_valid_o, fil_chunk_wr_valid_o;
   logic [1:0]        ifm_chunk_wr_count_o, fil_chunk_wr_count_o;
   logic              ifm_chunk_wr_sel_o, fil_chunk_wr_sel_o;
   logic [CU_NUM-1:0] fil_chunk_cu_wr_sel_o;
   logic              ifm_chunk_rd_sel_o, fil_chunk_rd_sel_o;
   logic              total_chunk_start_o, run_valid_o;
   logic              total_chunk_end_i = 1'b0;
   logic [2:0]        com_unit_out_buf_sel_o;
   logic              out_valid_o;
   logic              out_ready_i = 1'b0;
   logic              out_last_o;

   cluster_chunk_sched #(
      .CU_NUM (CU_NUM),
      .WR_CYC (WR_CYC),
      .CNT_W  (CNT_W)
   ) dut (
      .clk_i                  (clk_i),
      .rst_i                  (rst_i),
      .start_i                (start_i),
      .chunk_num_i            (chunk_num_i),
      .busy_o                 (busy_o),
      .done_o                 (done_o),
      .src_valid_i            (src_valid_i),
      .src_ready_o            (src_ready_o),
      .ifm_chunk_wr_valid_o   (ifm_chunk_wr_valid_o),
      .ifm_chunk_wr_count_o   (ifm_chunk_wr_count_o),
      .ifm_chunk_wr_sel_o     (ifm_chunk_wr_sel_o),
      .fil_chunk_wr_valid_o   (fil_chunk_wr_valid_o),
      .fil_chunk_wr_count_o   (fil_chunk_wr_count_o),
      .fil_chunk_wr_sel_o     (fil_chunk_wr_sel_o),
      .fil_chunk_cu_wr_sel_o  (fil_chunk_cu_wr_sel_o),
      .ifm_chunk_rd_sel_o     (ifm_chunk_rd_sel_o),
      .fil_chunk_rd_sel_o     (fil_chunk_rd_sel_o),
      .total_chunk_start_o    (total_chunk_start_o),
      .run_valid_o            (run_valid_o),
      .total_chunk_end_i      (total_chunk_end_i),
      .com_unit_out_buf_sel_o (com_unit_out_buf_sel_o),
      .out_valid_o            (out_valid_o),
      .out_ready_i            (out_ready_i),
      .out_last_o             (out_last_o)
   );

   always #5 clk_i = ~clk_i;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // Stimulus knobs.
   bit          gap_mode = 1'b0;
   int unsigned vpct = 100;
   int          end_delay = 5;
   int          ready_mode = 0;

   // Reference model: job progress as plain counts.
   bit busy_m = 1'b0, drain_m = 1'b0, run_m = 1'b0, start_m = 1'b0, done_m = 1'b0;
   int n_m = 0, loaded = 0, finished = 0, beat = 0, age_m = 0, sel_m = 0;
   bit acc_m;
   int starts_seen, beats_seen;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_cycle();
      bit act, rdy, ifm;
      int cu, cnt;
      act = busy_m && !drain_m;
      rdy = act && (loaded < n_m) && ((loaded - finished) < 2);
      acc_m = src_valid_i && rdy;
      ifm = beat < WR_CYC;
      cu  = ifm ? 0 : (beat - WR_CYC) / WR_CYC;
      cnt = beat % WR_CYC;
      if (total_chunk_start_o === 1'b1) starts_seen++;
      if ((ifm_chunk_wr_valid_o | fil_chunk_wr_valid_o) === 1'b1) beats_seen++;
      chk("src_ready", 32'(src_ready_o), 32'(rdy));
      chk("ifm_valid", 32'(ifm_chunk_wr_valid_o), 32'(acc_m && ifm));
      chk("fil_valid", 32'(fil_chunk_wr_valid_o), 32'(acc_m && !ifm));
      if (acc_m && ifm) begin
         chk("ifm_count", 32'(ifm_chunk_wr_count_o), 32'(cnt));
         chk("ifm_sel", 32'(ifm_chunk_wr_sel_o), 32'(loaded % 2));
      end
      if (acc_m && !ifm) begin
         chk("fil_count", 32'(fil_chunk_wr_count_o), 32'(cnt));
         chk("fil_sel", 32'(fil_chunk_wr_sel_o), 32'(loaded % 2));
         chk("cu_sel", 32'(fil_chunk_cu_wr_sel_o), 32'(1) << cu);
      end
      chk("chunk_start", 32'(total_chunk_start_o), 32'(start_m));
      chk("run_valid", 32'(run_valid_o), 32'(run_m));
      chk("ifm_rd_sel", 32'(ifm_chunk_rd_sel_o), 32'(finished % 2));
      chk("fil_rd_sel", 32'(fil_chunk_rd_sel_o), 32'(finished % 2));
      chk("out_valid", 32'(out_valid_o), 32'(drain_m));
      chk("out_buf_sel", 32'(com_unit_out_buf_sel_o), 32'(sel_m));
      chk("out_last", 32'(out_last_o), 32'(drain_m && (sel_m == CU_NUM - 1)));
      chk("done", 32'(done_o), 32'(done_m));
      chk("busy", 32'(busy_o), 32'(busy_m));
   endtask

   task automatic update_model();
      bit end_ev;
      if (rst_i) begin
         busy_m = 0; drain_m = 0; run_m = 0; start_m = 0; done_m = 0;
         loaded = 0; finished = 0; beat = 0; age_m = 0; sel_m = 0;
         return;
      end
      start_m = 0;
      done_m  = 0;
      if (!busy_m) begin
         if (start_i) begin
            n_m = int'(chunk_num_i);
            loaded = 0; finished = 0; beat = 0; run_m = 0; sel_m = 0;
            if (n_m == 0) done_m = 1;
            else busy_m = 1;
         end
      end else if (!drain_m) begin
         if (acc_m) begin
            beat++;
            if (beat == BEATS) begin
               beat = 0;
               loaded++;
            end
         end
         end_ev = run_m && total_chunk_end_i;
         if (end_ev) begin
            finished++;
            run_m = 0;
         end else if (run_m) begin
            age_m++;
         end
         if (!run_m && (loaded > finished)) begin
            start_m = 1;
            run_m   = 1;
            age_m   = 0;
         end
         if (end_ev && (finished == n_m)) begin
            drain_m = 1;
            sel_m   = 0;
         end
      end else if (out_ready_i) begin
         if (sel_m == CU_NUM - 1) begin
            busy_m = 0; drain_m = 0; sel_m = 0; done_m = 1;
         end else begin
            sel_m++;
         end
      end
   endtask

   // One clock: drive inputs just after the edge, check mid-cycle, advance the model.
   task automatic step(input bit do_start, input bit do_rst);
      @(posedge clk_i);
      #1;
      cyc++;
      rst_i   = do_rst;
      start_i = do_start;
      src_valid_i = gap_mode ? (cyc % 3 == 0) : ($urandom_range(0, 99) < vpct);
      if (run_m) total_chunk_end_i = (age_m >= end_delay);
      else total_chunk_end_i = ($urandom_range(0, 3) == 0);
      case (ready_mode)
         0: out_ready_i = 1'b1;
         1: out_ready_i = (cyc % 2 == 1);
         default: out_ready_i = ($urandom_range(0, 1) == 1);
      endcase
      @(negedge clk_i);
      check_cycle();
      update_model();
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_ifm_cnt"}, 32'(ifm_chunk_wr_count_o), 0);
      chk({tag, "_fil_cnt"}, 32'(fil_chunk_wr_count_o), 0);
      chk({tag, "_wr_sel"}, 32'({ifm_chunk_wr_sel_o, fil_chunk_wr_sel_o}), 0);
      chk({tag, "_cu_sel"}, 32'(fil_chunk_cu_wr_sel_o), 0);
   endtask

   task automatic run_job(input int n, input bit gap, input int unsigned vp, input int dly,
                          input int rdy, input bit abort, input bit noise);
      int steps;
      gap_mode = gap; vpct = vp; end_delay = dly; ready_mode = rdy;
      chunk_num_i = CNT_W'(n);
      starts_seen = 0;
      beats_seen  = 0;
      step(1'b1, 1'b0);
      steps = 0;
      while (!done_m && steps < 20000) begin
         if (abort && loaded == 1 && beat == WR_CYC + 5) begin
            step(1'b0, 1'b1);
            step(1'b0, 1'b0);
            check_zero_outputs("abort");
            step(1'b0, 1'b0);
            return;
         end
         step(noise && busy_m && ($urandom_range(0, 19) == 0), 1'b0);
         steps++;
      end
      chk("job_timeout", 32'(steps >= 20000), 0);
      step(1'b0, 1'b0);
      chk("start_pulses", 32'(starts_seen), 32'(n));
      chk("beat_total", 32'(beats_seen), 32'(n * BEATS));
   endtask

   initial begin
      // Reset and idle state.
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      check_zero_outputs("reset");

      // Single chunk, continuous source.
      run_job(1, 1'b0, 100, 5, 0, 1'b0, 1'b0);
      // Overlap: three chunks, long compute.
      run_job(3, 1'b0, 100, 100, 0, 1'b0, 1'b0);
      // Drain backpressure with alternating ready.
      run_job(2, 1'b0, 100, 10, 1, 1'b0, 1'b0);
      // Zero-length job.
      run_job(0, 1'b0, 100, 5, 0, 1'b0, 1'b0);
      // Source gaps, one beat in three.
      run_job(1, 1'b1, 100, 5, 0, 1'b0, 1'b0);
      // Reset during chunk 2 filter load, then a fresh single chunk.
      run_job(3, 1'b0, 100, 60, 0, 1'b1, 1'b0);
      run_job(1, 1'b0, 100, 5, 0, 1'b0, 1'b0);
      // Randomised jobs with stray start pulses while busy.
      for (int i = 0; i < 8; i++) begin
         run_job(int'($urandom_range(1, 4)), 1'b0, $urandom_range(30, 100),
                 int'($urandom_range(1, 60)), 2, 1'b0, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cluster_chunk_sched.md
# cluster_chunk_sched

Chunk scheduler for the compute cluster in channel-padding mode. Accepts a job (number of chunks to accumulate) and meters an upstream beat stream into the cluster's double-buffered IFM and filter chunk stores. Loading of chunk n+1 overlaps computation of chunk n. After the last chunk it sweeps the compute-unit output buffers out through a valid/ready port.

## Interface
- CU_NUM, 8, number of compute units (one filter chunk each)
- WR_CYC, 4, write beats per chunk per store (power of 2, ≥2)
- CNT_W, 16, width of the chunk-count field
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, synchronous, active-high
- start_i  in  1  job start pulse; ignored while busy_o=1
- chunk_num_i  in  CNT_W  chunks in job; sampled with start_i
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle pulse at job completion
- src_valid_i  in  1  upstream beat valid (sparsemap/data go straight to cluster)
- src_ready_o  out  1  beat accepted when src_valid_i & src_ready_o
- ifm_chunk_wr_valid_o  out  1  IFM store write strobe
- ifm_chunk_wr_count_o  out  $clog2(WR_CYC)  IFM beat index
- ifm_chunk_wr_sel_o  out  1  IFM write bank
- fil_chunk_wr_valid_o  out  1  filter store write strobe
- fil_chunk_wr_count_o  out  $clog2(WR_CYC)  filter beat index
- fil_chunk_wr_sel_o  out  1  filter write bank
- fil_chunk_cu_wr_sel_o  out  CU_NUM  one-hot target compute unit
- ifm_chunk_rd_sel_o, fil_chunk_rd_sel_o  out  1  read bank (same value)
- total_chunk_start_o  out  1  one-cycle chunk compute start
- run_valid_o  out  1  cluster run enable
- total_chunk_end_i  in  1  cluster reports chunk compute finished
- com_unit_out_buf_sel_o  out  $clog2(CU_NUM)  output buffer being drained
- out_valid_o  out  1  drained word valid
- out_ready_i  in  1  downstream accepts word
- out_last_o  out  1  word from CU_NUM-1

## Operation
- State: IDLE, ACTIVE (loader and compute run concurrently), DRAIN.
- Bank state: wr_bank, rd_bank, full[1:0]. All are cleared by reset and by start_i.
- Counters:
  - load_cnt and comp_cnt (CNT_W bits).
  - beat index: IFM phase plus CU index 0..CU_NUM-1, and a count 0..WR_CYC-1.
- Chunk beat order: WR_CYC IFM beats, then WR_CYC beats for CU0, CU1, …, CU_NUM-1. Total WR_CYC·(1+CU_NUM) beats.
- src_ready_o = ACTIVE & load_cnt<chunk_num & !full[wr_bank].
- Write strobes are combinational from the accepted beat. Only one of ifm/fil_chunk_wr_valid_o is high, selected by phase.
  - count = beat index.
  - wr_sel = wr_bank.
  - fil_chunk_cu_wr_sel_o = one-hot CU index during filter phase, 0 otherwise.
- Last beat of chunk accepted: full[wr_bank]←1, wr_bank toggles, load_cnt++, beat index wraps to IFM/0.
- Compute, when idle with full[rd_bank]=1 and comp_cnt<chunk_num:
  - Pulse total_chunk_start_o.
  - Raise run_valid_o.
  - Hold until total_chunk_end_i=1 is sampled, then drop run_valid_o.
  - full[rd_bank]←0, rd_bank toggles, comp_cnt++.
- Setting full on one bank and clearing it on the other in the same cycle are both honoured.
- comp_cnt reaches chunk_num → DRAIN:
  - com_unit_out_buf_sel_o counts 0..CU_NUM-1 with out_valid_o=1.
  - Advance only on out_valid_o & out_ready_i.
  - out_last_o=1 when the select is CU_NUM-1.
- Handshake of the last word → IDLE, done_o pulse.
- chunk_num_i=0: no beats, no run, no drain; done_o pulses the cycle after start.

## Timing
- Reset value of every output is 0; the FSM resets to IDLE.
- Reset mid-job aborts at that edge: no done_o; the stores are not cleared.
- start_i sampled at edge T: busy_o=1 and src_ready_o=1 from T+1.
- Write strobes have zero latency relative to the accepted beat.
- Last beat accepted at edge T:
  - total_chunk_start_o=1 and run_valid_o=1 in cycle T+1 (if compute is idle).
  - rd_sel already equals that bank in T+1.
- total_chunk_end_i sampled at edge E: run_valid_o=0 from E+1.
  - The next chunk's start can pulse at E+1 if its bank is full.
  - src_ready_o may rise at E+1 if it was stalled on full.
- total_chunk_end_i is ignored while run_valid_o=0.
- First drain word is valid in the cycle after the final total_chunk_end_i sample.
- done_o is high in the cycle after the last out handshake; busy_o=0 in that same cycle.
- src_valid_i gaps and out_ready_i stalls hold all indices unchanged.

## Test plan
- **Single chunk:** CU_NUM=8, WR_CYC=4, chunk_num=1, continuous source → expected response:
  - Beats 0-3: IFM counts 0-3, sel 0.
  - Beats 4-35: cu_sel 0x01…0x80, count cycles 0-3.
  - total_chunk_start_o one cycle after beat 35, rd_sel 0.
- **Overlap:** chunk_num=3, end returned 100 cycles after each start → expected response:
  - Chunk 2 loads into bank 1 during compute 1.
  - src_ready_o=0 while both banks are full.
  - Chunk 3 enters bank 0 the cycle after end 1.
  - Exactly 3 start pulses.
- **Drain backpressure:** out_ready_i alternates 1/0 → expected response:
  - Select 0..7, each held until its handshake.
  - out_last_o only at select 7.
  - done_o one cycle after the 8th handshake.
- **Zero-length job:** chunk_num=0 → expected response:
  - done_o at T+1.
  - No write strobe, no run_valid_o, no out_valid_o.
- **Source gaps:** src_valid_i 1-in-3 → expected response:
  - Count/CU index advance only on accepted beats.
  - Strobe sequence identical to the single-chunk case.
- **Reset mid-job:** rst_i during chunk 2 filter load → expected response:
  - All outputs 0 next cycle, no done_o.
  - A new start_i with chunk_num=1 behaves as in the single-chunk case.
